// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle RV32 control sequencer.
// Walks each instruction through fetch, decode, execute, memory and write-back
// against req/gnt/rvalid instruction and data memories. It drives the PC, IR,
// register-file and memory strobes, and includes a bus-timeout watchdog.
// Optional feature macro: MC_PERF_CNT_EN adds the cycle and instret counters
// and their ports.
module mc_sequencer #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 64
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic [DW-1:0] ir,
    input  logic          is_mem_load,
    input  logic          is_mem_store,
    input  logic          is_jal,
    input  logic          is_jalr,
    input  logic          is_b_type,
    input  logic          is_system,
    input  logic          br_taken,
    output logic          dmem_req,
    output logic          dmem_we,
    input  logic          dmem_gnt,
    input  logic          dmem_rvalid,
    output logic          pc_we,
    output logic          pc_sel,
    output logic          rf_we,
    output logic          halted,
    output logic          bus_err
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    localparam logic [3:0] S_FETCH_REQ  = 4'd0;
    localparam logic [3:0] S_FETCH_WAIT = 4'd1;
    localparam logic [3:0] S_DECODE     = 4'd2;
    localparam logic [3:0] S_EXEC       = 4'd3;
    localparam logic [3:0] S_MEM_REQ    = 4'd4;
    localparam logic [3:0] S_MEM_WAIT   = 4'd5;
    localparam logic [3:0] S_WB         = 4'd6;
    localparam logic [3:0] S_HALT       = 4'd7;
    localparam logic [3:0] S_ERR        = 4'd8;

    // The watchdog counts 0..TIMEOUT-1 within one wait state, so clog2(TIMEOUT)
    // bits are enough; the last count without a handshake trips the error.
    localparam int        WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] TO_M1 = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit        WD_EN = (TIMEOUT != 0);

    logic [3:0]      state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [DW-1:0]   ir_q;
    logic            pc_sel_q;
    logic            st_q;     // current instruction is a store
    logic            nrf_q;    // current instruction does not write the register file
    logic            wd_exp;

    // Next-state logic; a handshake in its wait state always beats the watchdog.
    always_comb begin
        state_d = state_q;
        wd_exp  = WD_EN && (wd_q == TO_M1);
        case (state_q)
            S_FETCH_REQ: begin
                if (imem_gnt)    state_d = S_FETCH_WAIT;
                else if (wd_exp) state_d = S_ERR;
            end
            S_FETCH_WAIT: begin
                if (imem_rvalid) state_d = S_DECODE;
                else if (wd_exp) state_d = S_ERR;
            end
            S_DECODE:  state_d = is_system ? S_HALT : S_EXEC;
            S_EXEC:    state_d = (is_mem_load | is_mem_store) ? S_MEM_REQ : S_WB;
            S_MEM_REQ: begin
                if (dmem_gnt)    state_d = S_MEM_WAIT;
                else if (wd_exp) state_d = S_ERR;
            end
            S_MEM_WAIT: begin
                if (dmem_rvalid) state_d = S_WB;
                else if (wd_exp) state_d = S_ERR;
            end
            S_WB:      state_d = S_FETCH_REQ;
            S_HALT:    state_d = S_HALT;
            S_ERR:     state_d = S_ERR;
            default:   state_d = S_ERR;
        endcase
    end

    // Watchdog restarts on every state change and saturates at its limit.
    always_comb begin
        wd_d = wd_q;
        if (state_d != state_q)            wd_d = '0;
        else if (WD_EN && (wd_q != TO_M1)) wd_d = wd_q + 1'b1;
    end

    // State, instruction register and per-instruction control latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH_REQ;
            wd_q     <= '0;
            ir_q     <= '0;
            pc_sel_q <= 1'b0;
            st_q     <= 1'b0;
            nrf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (state_q == S_FETCH_WAIT && imem_rvalid) ir_q <= imem_rdata;
            // Latch the class once in EXEC so later strobes do not depend on
            // the decoder inputs staying stable through the memory phase.
            if (state_q == S_EXEC) begin
                pc_sel_q <= is_jal | is_jalr | (is_b_type & br_taken);
                st_q     <= is_mem_store;
                nrf_q    <= is_mem_store | is_b_type;
            end
        end
    end

    assign imem_req = (state_q == S_FETCH_REQ);
    assign dmem_req = (state_q == S_MEM_REQ);
    assign dmem_we  = dmem_req & st_q;
    assign pc_we    = (state_q == S_WB);
    assign rf_we    = pc_we & ~nrf_q;
    assign pc_sel   = pc_sel_q;
    assign ir       = ir_q;
    assign halted   = (state_q == S_HALT);
    assign bus_err  = (state_q == S_ERR);

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, ret_q;

    // Free-running counters that stop once the core is halted or faulted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state_q != S_HALT && state_q != S_ERR) cyc_q <= cyc_q + 1'b1;
            if (state_q == S_WB)                       ret_q <= ret_q + 1'b1;
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;
`endif

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle control sequencer for the next-generation RV32 core, replacing the one-cycle-per-instruction control path. It steps each instruction through fetch, decode, execute, memory and write-back states against variable-latency instruction and data memories using a req/gnt/rvalid handshake. It emits the per-state write strobes (PC, IR, register file, memory) that gate the existing datapath units. A bus-timeout watchdog and optional performance counters are included.

## Interface
- DW, 32, instruction/data width
- TIMEOUT, 16, maximum cycles waited in any memory wait state; 0 disables the watchdog
- CNT_W, 64, performance counter width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_gnt  in  1  fetch request accepted
- imem_rvalid  in  1  fetch data valid
- imem_rdata  in  DW  fetch data
- ir  out  DW  instruction register
- is_mem_load, is_mem_store, is_jal, is_jalr, is_b_type, is_system  in  1 each  decoded class of `ir`
- br_taken  in  1  branch comparison result for `ir`
- dmem_req  out  1  data request
- dmem_we  out  1  data request is a store
- dmem_gnt  in  1  data request accepted
- dmem_rvalid  in  1  load data valid / store acknowledge
- pc_we  out  1  PC update strobe
- pc_sel  out  1  1 = jump target, 0 = PC+4
- rf_we  out  1  register-file write strobe
- halted  out  1  core stopped on a system instruction
- bus_err  out  1  watchdog expired
- cycle_cnt, instret_cnt  out  CNT_W each  performance counters (MC_PERF_CNT_EN only)

## Operation
- States: FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, ERR.
- FETCH_REQ: imem_req=1. On imem_gnt, go to FETCH_WAIT.
- FETCH_WAIT: on imem_rvalid, latch imem_rdata into ir and go to DECODE.
- DECODE: is_system goes to HALT. Otherwise go to EXEC.
- EXEC: register pc_sel = is_jal | is_jalr | (is_b_type & br_taken). A load or store goes to MEM_REQ; anything else goes to WB.
- MEM_REQ: dmem_req=1 and dmem_we=is_mem_store. On dmem_gnt, go to MEM_WAIT.
- MEM_WAIT: on dmem_rvalid, go to WB.
- WB: pc_we=1 for one cycle. rf_we=1 unless the instruction is a store or branch. Retire the instruction, then go to FETCH_REQ.
- HALT and ERR are terminal; only rst leaves them. All strobes are 0 in both.
- Watchdog: the counter clears on entry to FETCH_REQ, FETCH_WAIT, MEM_REQ or MEM_WAIT and increments each cycle spent in them. When it reaches TIMEOUT with no gnt/rvalid, go to ERR and set bus_err=1.
- pc_we and rf_we are single-cycle pulses, never both asserted outside WB.
- A gnt or rvalid arriving in a non-waiting state is ignored.

## Timing
- Reset values: state FETCH_REQ, ir=0, pc_sel=0, all strobes 0, halted=0, bus_err=0, counters 0.
- imem_req is combinational from state, so it is high in the first cycle after rst deasserts.
- With zero-wait memory (gnt in the request cycle, rvalid the next cycle):
  - ALU, jump and branch instructions take 5 cycles.
  - Loads and stores take 7 cycles.
- Each wait cycle on gnt or rvalid adds exactly one cycle.
- pc_sel is stable from the cycle after EXEC through WB.
- rst asserted mid-instruction takes effect at the next edge. The in-flight request is abandoned, and a later rvalid is ignored unless the FSM is in a waiting state.

## Configuration
- MC_PERF_CNT_EN defined:
  - cycle_cnt increments every cycle except in HALT and ERR.
  - instret_cnt increments on each WB cycle.
  - Both wrap modulo 2^CNT_W.
- MC_PERF_CNT_EN undefined: neither counter exists, neither port exists, and no counter logic is built.

## Test plan
- ALU instruction, zero-wait memory → DECODE in cycle 3, pc_we and rf_we high in cycle 5, pc_sel=0, imem_req high again in cycle 6.
- Load with dmem_gnt delayed 3 cycles → dmem_req held 4 cycles with dmem_we=0, instruction completes in 10 cycles, rf_we=1 in WB.
- Taken branch (is_b_type=1, br_taken=1) → pc_sel=1 and pc_we=1 in WB with rf_we=0. Store → dmem_we=1 and rf_we=0.
- Watchdog: TIMEOUT=4 with imem_rvalid never asserted → bus_err=1 after 4 cycles in FETCH_WAIT, outputs frozen until rst.
- is_system=1 → halted=1 after DECODE, no pc_we. Pulsing rst restarts fetch with imem_req=1 in the next cycle.
- MC_PERF_CNT_EN with CNT_W=4 → instret_cnt reads 0 after the 16th retirement, and cycle_cnt wraps identically.
